// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with a show-ahead output FIFO.
// Frames run DATA_BITS data bits (LSB first), optional parity and
// STOP_BITS stop bits, sampled OVERSAMPLE clken ticks per bit.
// Ports:
//   clk_50m    system clock
//   reset      synchronous active-high reset
//   clken      oversample tick, one cycle wide
//   Rx         asynchronous serial input, idle high
//   data       FIFO head word (valid while ready=1)
//   ready      FIFO non-empty
//   ready_clr  pop FIFO head (ignored when empty)
//   frame_err  sticky: stop bit sampled low
//   parity_err sticky: parity mismatch
//   overrun    sticky: good word dropped because FIFO was full
//   err_clr    clears the sticky flags (a same-cycle set wins)
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_50m,
  input  logic                 reset,
  input  logic                 clken,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 ready,
  input  logic                 ready_clr,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 err_clr
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic          LAST_STP = 1'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW + 1)'(1);
  localparam logic          ODD_PAR  = (PARITY == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_n;
  logic                 rx_meta, rxs;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad, stop_bad;

  logic                 mid_hit, ctr_hit, frame_done, bad_frame;
  logic                 good_word, frame_set, par_set;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0]          count;
  logic                 fifo_pop, fifo_full, fifo_push, ovr_set;

  // Two-flop synchroniser, preset to the idle level.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rxs     <= rx_meta;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk_50m) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // FSM: next state.
  always_comb begin
    state_n = state;
    if (clken) begin
      case (state)
        IDLE:    if (!rxs) state_n = START;
        START:   if (mid_hit) state_n = rxs ? IDLE : DATA;
        DATA:    if (ctr_hit && bit_idx == LAST_BIT)
                   state_n = (PARITY != 0) ? PAR : STOP;
        PAR:     if (ctr_hit) state_n = STOP;
        STOP:    if (ctr_hit && stop_idx == LAST_STP) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // FSM: decoded outputs. The final stop sample is folded into bad_frame
  // so completion can be judged on the same tick it is taken.
  always_comb begin
    mid_hit    = (cnt == MID_CNT);
    ctr_hit    = (cnt == LAST_CNT);
    bad_frame  = stop_bad | ~rxs;
    frame_done = clken && (state == STOP) && ctr_hit && (stop_idx == LAST_STP);
    good_word  = frame_done && !bad_frame && !par_bad;
    frame_set  = frame_done && bad_frame;
    par_set    = frame_done && !bad_frame && par_bad;
  end

  // Sample counter and frame datapath.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
    end else if (clken) begin
      case (state)
        IDLE: cnt <= '0;
        START: begin
          if (mid_hit) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (ctr_hit) begin
            cnt            <= '0;
            shift[bit_idx] <= rxs;
            bit_idx        <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PAR: begin
          if (ctr_hit) begin
            cnt     <= '0;
            par_bad <= rxs ^ (^shift) ^ ODD_PAR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (ctr_hit) begin
            cnt      <= '0;
            stop_bad <= bad_frame;
            stop_idx <= stop_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    ready     = (count != '0);
    fifo_pop  = ready_clr && ready;
    fifo_full = (count == FULL_CNT);
    fifo_push = good_word && (!fifo_full || fifo_pop);
    ovr_set   = good_word && fifo_full && !fifo_pop;
    rd_nxt    = rd_ptr + 1'b1;
  end

  always_ff @(posedge clk_50m) begin
    if (fifo_push) mem[wr_ptr] <= shift;
  end

  // data is a registered copy of the head so it can hold its last value
  // once the FIFO drains; the pushed word is bypassed when it becomes head.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      data   <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_nxt;
      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (fifo_push && (count == '0 || (fifo_pop && count == ONE_CNT)))
        data <= shift;
      else if (fifo_pop && count > ONE_CNT)
        data <= mem[rd_nxt];
    end
  end

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (frame_set)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (par_set)      parity_err <= 1'b1;
      else if (err_clr) parity_err <= 1'b0;
      if (ovr_set)      overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (default 8N1, even parity,
// 7 data bits with 2 stop bits) share clock and reset. Expected words are
// queued when a good frame is driven and compared as the FIFO is popped.
module tb_uart_rx_param;

  localparam int TICK_CLKS = 4;
  localparam int BIT_CLKS  = 16 * TICK_CLKS;

  logic       clk_50m, reset, clken;
  logic       rx0, rx1, rx2;
  logic       clr0, clr1, clr2;
  logic       eclr0, eclr1, eclr2;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic       rdy0, rdy1, rdy2;
  logic       fe0, fe1, fe2, pe0, pe1, pe2, ov0, ov1, ov2;

  int checks = 0;
  int errors = 0;

  logic [8:0] sb0[$];
  logic [8:0] sb1[$];
  logic [8:0] sb2[$];

  uart_rx_param u_def (
    .clk_50m(clk_50m), .reset(reset), .clken(clken), .Rx(rx0),
    .data(d0), .ready(rdy0), .ready_clr(clr0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .err_clr(eclr0)
  );

  uart_rx_param #(.PARITY(1)) u_par (
    .clk_50m(clk_50m), .reset(reset), .clken(clken), .Rx(rx1),
    .data(d1), .ready(rdy1), .ready_clr(clr1),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .err_clr(eclr1)
  );

  uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) u_72 (
    .clk_50m(clk_50m), .reset(reset), .clken(clken), .Rx(rx2),
    .data(d2), .ready(rdy2), .ready_clr(clr2),
    .frame_err(fe2), .parity_err(pe2), .overrun(ov2), .err_clr(eclr2)
  );

  initial begin
    clk_50m = 1'b0;
    forever #10 clk_50m = ~clk_50m;
  end

  initial begin
    clken = 1'b0;
    forever begin
      repeat (TICK_CLKS - 1) @(negedge clk_50m);
      clken = 1'b1;
      @(negedge clk_50m);
      clken = 1'b0;
    end
  end

  function automatic logic rd_ready(input int i);
    case (i)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  function automatic logic [8:0] rd_data(input int i);
    case (i)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      default: return {2'b00, d2};
    endcase
  endfunction

  function automatic logic [2:0] rd_flags(input int i);
    case (i)
      0:       return {fe0, pe0, ov0};
      1:       return {fe1, pe1, ov1};
      default: return {fe2, pe2, ov2};
    endcase
  endfunction

  task automatic set_rx(input int i, input logic b);
    case (i)
      0:       rx0 = b;
      1:       rx1 = b;
      default: rx2 = b;
    endcase
  endtask

  task automatic pulse_clr(input int i);
    case (i)
      0:       clr0 = 1'b1;
      1:       clr1 = 1'b1;
      default: clr2 = 1'b1;
    endcase
    @(negedge clk_50m);
    clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
  endtask

  task automatic pulse_eclr(input int i);
    case (i)
      0:       eclr0 = 1'b1;
      1:       eclr1 = 1'b1;
      default: eclr2 = 1'b1;
    endcase
    @(negedge clk_50m);
    eclr0 = 1'b0; eclr1 = 1'b0; eclr2 = 1'b0;
  endtask

  // Drives v[0] first, each bit held one bit time, then returns to idle.
  task automatic send_raw(input int i, input logic [15:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      set_rx(i, v[k]);
      repeat (BIT_CLKS) @(negedge clk_50m);
    end
    set_rx(i, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rd_ready(i), rd_data(i), rd_flags(i)} !== 13'h0) begin
        errors++;
        $display("FAIL reset_state inst%0d: ready=%b data=%h flags=%b, want 0/0/000",
                 i, rd_ready(i), rd_data(i), rd_flags(i));
      end
    end
  endtask

  task automatic test_basic();
    logic [8:0] exp;
    send_raw(0, {1'b1, 8'hA5, 1'b0}, 10);
    sb0.push_back(9'h0A5);
    checks++;
    if (rd_flags(0) !== 3'b000) begin
      errors++;
      $display("FAIL basic_flags: flags=%b want 000", rd_flags(0));
    end
    while (sb0.size() > 0) begin
      exp = sb0.pop_front();
      checks++;
      if (rdy0 !== 1'b1 || d0 !== exp[7:0]) begin
        errors++;
        $display("FAIL basic_word: ready=%b data=%h want ready=1 data=%h", rdy0, d0, exp[7:0]);
      end
      pulse_clr(0);
    end
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_after_pop: ready=%b want 0", rdy0);
    end
  endtask

  task automatic test_glitch();
    logic [8:0] exp;
    set_rx(0, 1'b0);
    repeat (4 * TICK_CLKS) @(negedge clk_50m);
    set_rx(0, 1'b1);
    repeat (BIT_CLKS) @(negedge clk_50m);
    checks++;
    if ({rdy0, rd_flags(0)} !== 4'b0000) begin
      errors++;
      $display("FAIL glitch_reject: ready=%b flags=%b want 0/000", rdy0, rd_flags(0));
    end
    send_raw(0, {1'b1, 8'h3C, 1'b0}, 10);
    sb0.push_back(9'h03C);
    while (sb0.size() > 0) begin
      exp = sb0.pop_front();
      checks++;
      if (rdy0 !== 1'b1 || d0 !== exp[7:0]) begin
        errors++;
        $display("FAIL glitch_next_word: ready=%b data=%h want ready=1 data=%h", rdy0, d0, exp[7:0]);
      end
      pulse_clr(0);
    end
  endtask

  task automatic test_empty_pop();
    logic [8:0] exp;
    pulse_clr(0);
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL empty_pop_ready: ready=%b want 0", rdy0);
    end
    send_raw(0, {1'b1, 8'h5A, 1'b0}, 10);
    sb0.push_back(9'h05A);
    while (sb0.size() > 0) begin
      exp = sb0.pop_front();
      checks++;
      if (rdy0 !== 1'b1 || d0 !== exp[7:0]) begin
        errors++;
        $display("FAIL empty_pop_word: ready=%b data=%h want ready=1 data=%h", rdy0, d0, exp[7:0]);
      end
      pulse_clr(0);
    end
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL empty_pop_drain: ready=%b want 0", rdy0);
    end
  endtask

  task automatic test_parity();
    logic [8:0] exp;
    logic       saw;
    // err_clr held across a bad-parity frame: the flag can only appear if set beats clear
    saw = 1'b0;
    eclr1 = 1'b1;
    fork
      send_raw(1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
      begin
        repeat (11 * BIT_CLKS) begin
          @(negedge clk_50m);
          if (pe1 === 1'b1) saw = 1'b1;
        end
      end
    join
    eclr1 = 1'b0;
    checks++;
    if (saw !== 1'b1) begin
      errors++;
      $display("FAIL parity_set_beats_clr: parity_err seen=%b want 1", saw);
    end
    send_raw(1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
    checks++;
    if ({rdy1, pe1, fe1} !== 3'b010) begin
      errors++;
      $display("FAIL parity_bad: ready=%b parity_err=%b frame_err=%b want 0/1/0", rdy1, pe1, fe1);
    end
    pulse_eclr(1);
    checks++;
    if (pe1 !== 1'b0) begin
      errors++;
      $display("FAIL parity_clear: parity_err=%b want 0", pe1);
    end
    send_raw(1, {1'b1, 1'b0, 8'h03, 1'b0}, 11);
    sb1.push_back(9'h003);
    send_raw(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    sb1.push_back(9'h007);
    checks++;
    if (pe1 !== 1'b0) begin
      errors++;
      $display("FAIL parity_good_flags: parity_err=%b want 0", pe1);
    end
    while (sb1.size() > 0) begin
      exp = sb1.pop_front();
      checks++;
      if (rdy1 !== 1'b1 || d1 !== exp[7:0]) begin
        errors++;
        $display("FAIL parity_word: ready=%b data=%h want ready=1 data=%h", rdy1, d1, exp[7:0]);
      end
      pulse_clr(1);
    end
    checks++;
    if (rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL parity_drain: ready=%b want 0", rdy1);
    end
  endtask

  task automatic test_frame_err();
    send_raw(0, {1'b0, 8'h55, 1'b0}, 10);
    repeat (BIT_CLKS) @(negedge clk_50m);
    checks++;
    if ({rdy0, fe0, pe0, ov0} !== 4'b0100) begin
      errors++;
      $display("FAIL frame_err_set: ready=%b flags=%b want 0/100", rdy0, rd_flags(0));
    end
    pulse_eclr(0);
    checks++;
    if (fe0 !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_clear: frame_err=%b want 0", fe0);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] words [5];
    logic [8:0] exp;
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int k = 0; k < 5; k++) begin
      send_raw(0, {1'b1, words[k], 1'b0}, 10);
      if (k < 4) sb0.push_back({1'b0, words[k]});
    end
    checks++;
    if (rd_flags(0) !== 3'b001) begin
      errors++;
      $display("FAIL overrun_flag: flags=%b want 001", rd_flags(0));
    end
    while (sb0.size() > 0) begin
      exp = sb0.pop_front();
      checks++;
      if (rdy0 !== 1'b1 || d0 !== exp[7:0]) begin
        errors++;
        $display("FAIL overrun_order: ready=%b data=%h want ready=1 data=%h", rdy0, d0, exp[7:0]);
      end
      pulse_clr(0);
    end
    checks++;
    if (rdy0 !== 1'b0 || d0 !== 8'h44) begin
      errors++;
      $display("FAIL overrun_drained: ready=%b data=%h want ready=0 data=44", rdy0, d0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [8:0] exp;
    send_raw(0, 16'b0000_0000_0001_1110, 5);
    reset = 1'b1;
    repeat (3) @(negedge clk_50m);
    reset = 1'b0;
    checks++;
    if ({rdy0, d0, rd_flags(0)} !== 12'h000) begin
      errors++;
      $display("FAIL midframe_reset: ready=%b data=%h flags=%b want 0/00/000", rdy0, d0, rd_flags(0));
    end
    repeat (6 * BIT_CLKS) @(negedge clk_50m);
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL midframe_no_push: ready=%b want 0", rdy0);
    end
    send_raw(0, {1'b1, 8'h81, 1'b0}, 10);
    sb0.push_back(9'h081);
    while (sb0.size() > 0) begin
      exp = sb0.pop_front();
      checks++;
      if (rdy0 !== 1'b1 || d0 !== exp[7:0]) begin
        errors++;
        $display("FAIL post_reset_word: ready=%b data=%h want ready=1 data=%h", rdy0, d0, exp[7:0]);
      end
      pulse_clr(0);
    end
  endtask

  task automatic test_7n2();
    logic [8:0] exp;
    send_raw(2, {2'b11, 7'h41, 1'b0}, 10);
    sb2.push_back(9'h041);
    send_raw(2, {1'b0, 1'b1, 7'h2A, 1'b0}, 10);
    repeat (BIT_CLKS) @(negedge clk_50m);
    checks++;
    if (rd_flags(2) !== 3'b100) begin
      errors++;
      $display("FAIL n2_second_stop: flags=%b want 100", rd_flags(2));
    end
    while (sb2.size() > 0) begin
      exp = sb2.pop_front();
      checks++;
      if (rdy2 !== 1'b1 || d2 !== exp[6:0]) begin
        errors++;
        $display("FAIL n2_word: ready=%b data=%h want ready=1 data=%h", rdy2, d2, exp[6:0]);
      end
      pulse_clr(2);
    end
    checks++;
    if (rdy2 !== 1'b0) begin
      errors++;
      $display("FAIL n2_drain: ready=%b want 0", rdy2);
    end
  endtask

  initial begin
    reset = 1'b1;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    eclr0 = 1'b0; eclr1 = 1'b0; eclr2 = 1'b0;
    repeat (4) @(negedge clk_50m);
    test_reset();
    reset = 1'b0;
    repeat (10) @(negedge clk_50m);
    test_basic();
    test_glitch();
    test_empty_pop();
    test_parity();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    test_7n2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
